// File: rtl/cfg_pkg.sv
// Shared types and default sizes for the serial configuration writer.
package cfg_pkg;
    localparam int SIZESRSTAT_DEF = 88;
    localparam int SIZESRDYN_DEF  = 16;
    localparam int BITCNT_W       = $clog2(SIZESRSTAT_DEF + 1);

    typedef enum logic [2:0] {IDLE, STAT, GAP_S, DYN, GAP_D} cfg_state_e;

    function automatic int bitcnt_w(input int n);
        return $clog2(n + 1);
    endfunction
endpackage

// File: rtl/cfg_bit_tick.sv
// Bit-period divisor: a single counter per serial bit that emits phase strobes
// so the writer never needs a divided clock net.
module cfg_bit_tick #(
    parameter int DIV_W = 5
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_bit_start,
    output logic             o_rise,
    output logic             o_bit_end,
    output logic             o_sclk_nxt
);
    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] w_half;
    logic [DIV_W-1:0] w_cnt_nxt;

    assign w_half      = i_div >> 1;
    assign o_bit_start = i_en && (r_cnt == '0);
    assign o_rise      = i_en && (r_cnt == w_half);
    assign o_bit_end   = i_en && (r_cnt == i_div - 1'b1);
    assign w_cnt_nxt   = (!i_en || o_bit_end) ? '0 : r_cnt + 1'b1;
    // sclk level for the coming cycle, so the top can hold sclk in a flop.
    assign o_sclk_nxt  = (w_cnt_nxt >= w_half);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_cnt <= '0;
        else       r_cnt <= w_cnt_nxt;
    end
endmodule

// File: rtl/cfg_serial_writer.sv
// Serial writer for the static and dynamic config shift registers: one FSM
// drives both frames at a runtime-selected bit rate with optional readback.
module cfg_serial_writer
    import cfg_pkg::*;
#(
    parameter int SIZESRSTAT = SIZESRSTAT_DEF,
    parameter int SIZESRDYN  = SIZESRDYN_DEF,
    parameter int DIV_FAST   = 8,
    parameter int DIV_SLOW   = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start,
    input  logic                  mode_slow,
    input  logic                  dyn_only,
    input  logic                  verify_en,
    input  logic [SIZESRSTAT-1:0] stat_word,
    input  logic [SIZESRDYN-1:0]  dyn_word,
    input  logic                  miso,
    output logic                  sclk,
    output logic                  mosi,
    output logic                  sel,
    output logic                  busy,
    output logic                  done,
    output logic                  verify_err
);
    localparam int DIV_MAX   = (DIV_FAST > DIV_SLOW) ? DIV_FAST : DIV_SLOW;
    localparam int DIV_W     = $clog2(DIV_MAX + 1);
    localparam int CNT_W     = bitcnt_w(SIZESRSTAT);
    localparam int DYN_SHIFT = SIZESRSTAT - SIZESRDYN;

    cfg_state_e            r_state;
    logic [DIV_W-1:0]      r_div;
    logic                  r_verify;
    logic [SIZESRSTAT-1:0] r_stat;
    logic [SIZESRDYN-1:0]  r_dyn;
    logic [SIZESRSTAT-1:0] r_sr;
    logic [CNT_W-1:0]      r_bitcnt;
    logic                  r_pass;
    logic                  r_sclk, r_mosi, r_sel, r_busy, r_done, r_verr;

    logic                  w_en, w_in_frame, w_last;
    logic                  w_bit_start, w_rise, w_bit_end, w_sclk_nxt;
    logic [CNT_W-1:0]      w_len;
    logic [SIZESRSTAT-1:0] w_dyn_in, w_dyn_lat;

    assign w_en       = (r_state != IDLE);
    assign w_in_frame = (r_state == STAT) || (r_state == DYN);
    assign w_len      = (r_state == STAT) ? CNT_W'(SIZESRSTAT) : CNT_W'(SIZESRDYN);
    assign w_last     = (r_bitcnt == w_len - 1'b1);
    // Dynamic frame rides in the top bits so both frames shift out of the MSB.
    assign w_dyn_in   = SIZESRSTAT'(dyn_word) << DYN_SHIFT;
    assign w_dyn_lat  = SIZESRSTAT'(r_dyn) << DYN_SHIFT;

    cfg_bit_tick #(.DIV_W(DIV_W)) u_tick (
        .i_clk       (CLK),
        .i_rst       (RST),
        .i_en        (w_en),
        .i_div       (r_div),
        .o_bit_start (w_bit_start),
        .o_rise      (w_rise),
        .o_bit_end   (w_bit_end),
        .o_sclk_nxt  (w_sclk_nxt)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state  <= IDLE;
            r_div    <= '0;
            r_verify <= 1'b0;
            r_stat   <= '0;
            r_dyn    <= '0;
            r_sr     <= '0;
            r_bitcnt <= '0;
            r_pass   <= 1'b0;
            r_sclk   <= 1'b0;
            r_mosi   <= 1'b0;
            r_sel    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_verr   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_sclk <= w_sclk_nxt && w_in_frame;
            case (r_state)
                IDLE: if (start) begin
                    r_div    <= mode_slow ? DIV_W'(DIV_SLOW) : DIV_W'(DIV_FAST);
                    r_verify <= verify_en;
                    r_stat   <= stat_word;
                    r_dyn    <= dyn_word;
                    r_verr   <= 1'b0;
                    r_busy   <= 1'b1;
                    r_sel    <= 1'b1;
                    r_pass   <= 1'b0;
                    r_bitcnt <= '0;
                    if (dyn_only) begin
                        r_state <= DYN;
                        r_sr    <= w_dyn_in;
                        r_mosi  <= dyn_word[SIZESRDYN-1];
                    end else begin
                        r_state <= STAT;
                        r_sr    <= stat_word;
                        r_mosi  <= stat_word[SIZESRSTAT-1];
                    end
                end
                STAT, DYN: begin
                    // mosi already holds the MSB; advance so the next bit is on top.
                    if (w_bit_start) r_sr <= r_sr << 1;
                    // Second pass resends identical data, so the bit on mosi is the reference.
                    if (w_rise && r_pass && (miso != r_mosi)) r_verr <= 1'b1;
                    if (w_bit_end) begin
                        if (w_last) begin
                            r_state  <= (r_state == STAT) ? GAP_S : GAP_D;
                            r_sel    <= 1'b0;
                            r_mosi   <= 1'b0;
                            r_bitcnt <= '0;
                        end else begin
                            r_bitcnt <= r_bitcnt + 1'b1;
                            r_mosi   <= r_sr[SIZESRSTAT-1];
                        end
                    end
                end
                GAP_S: if (w_bit_end) begin
                    r_sel <= 1'b1;
                    if (r_verify && !r_pass) begin
                        r_pass  <= 1'b1;
                        r_state <= STAT;
                        r_sr    <= r_stat;
                        r_mosi  <= r_stat[SIZESRSTAT-1];
                    end else begin
                        r_pass  <= 1'b0;
                        r_state <= DYN;
                        r_sr    <= w_dyn_lat;
                        r_mosi  <= r_dyn[SIZESRDYN-1];
                    end
                end
                GAP_D: if (w_bit_end) begin
                    if (r_verify && !r_pass) begin
                        r_pass  <= 1'b1;
                        r_state <= DYN;
                        r_sel   <= 1'b1;
                        r_sr    <= w_dyn_lat;
                        r_mosi  <= r_dyn[SIZESRDYN-1];
                    end else begin
                        r_pass  <= 1'b0;
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign sclk       = r_sclk;
    assign mosi       = r_mosi;
    assign sel        = r_sel;
    assign busy       = r_busy;
    assign done       = r_done;
    assign verify_err = r_verr;
endmodule

// File: tb/tb_cfg_serial_writer.sv
// Directed bench for cfg_serial_writer: frame scoreboard, loopback target model on miso.
module tb_cfg_serial_writer;
    typedef struct {
        logic [87:0] word;
        int          len;
        int          div;
        bit          dyn;
        bit          corrupt;
        bit          chk_gap;
    } frm_t;

    localparam logic [87:0] S1   = 88'hFEDCBA9876543210012345;
    localparam logic [15:0] D1   = 16'h4321;
    localparam logic [87:0] ONES = '1;

    logic        CLK = 1'b0, RST = 1'b1;
    logic        start = 1'b0, mode_slow = 1'b0, dyn_only = 1'b0, verify_en = 1'b0;
    logic        miso = 1'b0;
    logic [87:0] stat_word = '0;
    logic [15:0] dyn_word = '0;
    logic        sclk, mosi, sel, busy, done, verify_err;

    int   ncmp = 0;
    int   nfail = 0;
    frm_t exp_q[$];

    cfg_serial_writer dut (
        .CLK(CLK), .RST(RST), .start(start), .mode_slow(mode_slow), .dyn_only(dyn_only),
        .verify_en(verify_en), .stat_word(stat_word), .dyn_word(dyn_word), .miso(miso),
        .sclk(sclk), .mosi(mosi), .sel(sel), .busy(busy), .done(done), .verify_err(verify_err)
    );

    always #5 CLK = ~CLK;

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_i(input string tag, input int obs, input int exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_w(input string tag, input logic [87:0] obs, input logic [87:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void push_seq(input logic slow, input logic dyno, input logic ver,
                                     input logic [87:0] s, input logic [15:0] d, input bit corr);
        frm_t f;
        bit   first = 1'b1;
        int   dv = slow ? 16 : 8;
        if (!dyno) begin
            for (int p = 0; p < (ver ? 2 : 1); p++) begin
                f.word = s; f.len = 88; f.div = dv; f.dyn = 1'b0; f.corrupt = 1'b0;
                f.chk_gap = !first;
                exp_q.push_back(f);
                first = 1'b0;
            end
        end
        for (int p = 0; p < (ver ? 2 : 1); p++) begin
            f.word = {72'h0, d}; f.len = 16; f.div = dv; f.dyn = 1'b1;
            f.corrupt = corr && (p == 1);
            f.chk_gap = !first;
            exp_q.push_back(f);
            first = 1'b0;
        end
    endfunction

    function automatic int exp_busy(input logic slow, input logic dyno, input logic ver);
        return ((dyno ? 0 : 89) + 17) * (slow ? 16 : 8) * (ver ? 2 : 1);
    endfunction

    // Called on the first busy cycle; returns on the cycle after done.
    task automatic wait_done(input int exp, input string tag);
        int n = 0;
        while (busy === 1'b1 && n < 5000) begin
            n++;
            @(negedge CLK);
        end
        chk_i({tag, "_busy_len"}, n, exp);
        chk_b({tag, "_done"}, done, 1'b1);
        @(negedge CLK);
        chk_b({tag, "_done_pulse"}, done, 1'b0);
    endtask

    task automatic run(input logic slow, input logic dyno, input logic ver,
                       input logic [87:0] s, input logic [15:0] d, input bit corr, input string tag);
        push_seq(slow, dyno, ver, s, d, corr);
        @(negedge CLK);
        mode_slow = slow; dyn_only = dyno; verify_en = ver; stat_word = s; dyn_word = d; start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        chk_b({tag, "_busy_rise"}, busy, 1'b1);
        chk_b({tag, "_verr_clr"}, verify_err, 1'b0);
        mode_slow = ~slow; dyn_only = ~dyno; verify_en = ~ver; stat_word = ~s; dyn_word = ~d;
        wait_done(exp_busy(slow, dyno, ver), tag);
    endtask

    // Monitor: frame capture/scoreboard plus a target shift register echoing on miso.
    frm_t        cur, exp_f;
    bit          has_cur = 1'b0;
    logic        prev_sel = 1'b0, prev_sclk = 1'b0, cap_bit = 1'b0;
    logic [87:0] cap = '0, lb_sr = '0;
    int          nbits = 0, sel_cnt = 0, low_cnt = 0, hi_cnt = 0, bidx = 0;

    always @(negedge CLK) begin
        if (RST) begin
            prev_sel = 1'b0; prev_sclk = 1'b0; has_cur = 1'b0;
            low_cnt = 0; bidx = 0; miso = 1'b0;
        end else begin
            if (!sel && prev_sel) begin
                chk_b("frame_queued", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) begin
                    exp_f = exp_q.pop_front();
                    chk_w("frame_word", cap, exp_f.word);
                    chk_i("frame_bits", nbits, exp_f.len);
                    chk_i("sel_len", sel_cnt, exp_f.len * exp_f.div);
                end
                low_cnt = 0;
            end
            if (sel && !prev_sel) begin
                chk_b("frame_expected", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) begin
                    cur = exp_q[0];
                    has_cur = 1'b1;
                    if (cur.chk_gap) chk_i("gap_len", low_cnt, cur.div);
                end
                cap = '0; nbits = 0; sel_cnt = 0; bidx = 0;
            end
            if (!sclk && prev_sclk) begin
                chk_i("sclk_high", hi_cnt, cur.div / 2);
                lb_sr = {lb_sr[86:0], cap_bit};
                bidx++;
            end
            if (sclk && !prev_sclk) begin
                cap = {cap[86:0], mosi};
                cap_bit = mosi;
                nbits++;
                hi_cnt = 0;
            end
            if (sel) sel_cnt++;
            else     low_cnt++;
            if (sclk) hi_cnt++;
            if (!sel) chk_b("idle_lines", sclk | mosi, 1'b0);
            prev_sel = sel;
            prev_sclk = sclk;
            miso = (cur.dyn ? lb_sr[15] : lb_sr[87]) ^ (has_cur && cur.corrupt && sel && bidx == 3);
        end
    end

    initial begin
        repeat (2) @(negedge CLK);
        chk_b("rst_sclk", sclk, 1'b0);
        chk_b("rst_mosi", mosi, 1'b0);
        chk_b("rst_sel", sel, 1'b0);
        chk_b("rst_busy", busy, 1'b0);
        chk_b("rst_done", done, 1'b0);
        chk_b("rst_verr", verify_err, 1'b0);
        #2 RST = 1'b0;

        run(1'b0, 1'b0, 1'b0, S1, D1, 1'b0, "t1_fast");
        run(1'b1, 1'b0, 1'b0, S1, D1, 1'b0, "t2_slow");
        run(1'b0, 1'b1, 1'b0, S1, 16'hABCD, 1'b0, "t3_dynonly");
        run(1'b0, 1'b0, 1'b1, S1, D1, 1'b0, "t4_verify_ok");
        chk_b("t4_verr_ok", verify_err, 1'b0);
        run(1'b0, 1'b0, 1'b1, S1, D1, 1'b1, "t4_verify_bad");
        chk_b("t4_verr_set", verify_err, 1'b1);

        // Reset in the middle of static bit 40.
        push_seq(1'b0, 1'b0, 1'b0, ONES, D1, 1'b0);
        @(negedge CLK);
        mode_slow = 1'b0; dyn_only = 1'b0; verify_en = 1'b0; stat_word = ONES; dyn_word = D1; start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        chk_b("t5_verr_cleared", verify_err, 1'b0);
        repeat (40 * 8 + 4) @(negedge CLK);
        chk_b("t5_pre_sel", sel, 1'b1);
        chk_b("t5_pre_sclk", sclk, 1'b1);
        chk_b("t5_pre_mosi", mosi, 1'b1);
        #2 RST = 1'b1;
        #1;
        chk_b("t5_rst_sclk", sclk, 1'b0);
        chk_b("t5_rst_mosi", mosi, 1'b0);
        chk_b("t5_rst_sel", sel, 1'b0);
        chk_b("t5_rst_busy", busy, 1'b0);
        exp_q.delete();
        @(negedge CLK);
        #2 RST = 1'b0;
        run(1'b0, 1'b0, 1'b0, S1, D1, 1'b0, "t5_after");

        // start held high; mode changes while busy only matter at the next accept.
        push_seq(1'b0, 1'b0, 1'b0, S1, D1, 1'b0);
        push_seq(1'b1, 1'b0, 1'b0, S1, D1, 1'b0);
        @(negedge CLK);
        mode_slow = 1'b0; dyn_only = 1'b0; verify_en = 1'b0; stat_word = S1; dyn_word = D1; start = 1'b1;
        @(negedge CLK);
        chk_b("t6_busy1", busy, 1'b1);
        mode_slow = 1'b1;
        wait_done(848, "t6_seq1");
        chk_b("t6_busy2", busy, 1'b1);
        mode_slow = 1'b0;
        start = 1'b0;
        wait_done(1696, "t6_seq2");
        repeat (20) @(negedge CLK);
        chk_b("t6_no_third", busy, 1'b0);

        chk_i("frames_left", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
